// File: rtl/msk_and_pini2_seq.sv
// msk_and_pini2_seq: feeds one masked operand pair plus fresh randomness into the
// 2-cycle PINI AND gadget (inb/rnd first, ina one cycle later) and registers its output sharing.
`default_nettype none

module msk_and_pini2_seq #(
   parameter  int D     = 2,
   localparam int N_RND = D * (D - 1) / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [D-1:0]     in_a,
   input  logic [D-1:0]     in_b,
   input  logic             rnd_valid,
   output logic             rnd_ready,
   input  logic [N_RND-1:0] rnd_in,
   output logic [D-1:0]     g_ina,
   output logic [D-1:0]     g_inb,
   output logic [N_RND-1:0] g_rnd,
   output logic             g_en,
   input  logic [D-1:0]     g_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [D-1:0]     out_data,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LB   = 2'd1;
   localparam logic [1:0] S_LA   = 2'd2;
   localparam logic [1:0] S_CAP  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [D-1:0]     a_reg;
   logic [D-1:0]     b_reg;
   logic [N_RND-1:0] r_reg;
   logic             out_free;
   logic             start;
   logic             capture;

   assign out_free  = !out_valid || out_ready;
   assign start     = ((state == S_IDLE) || ((state == S_CAP) && out_free))
                      && in_valid && rnd_valid && out_free;
   assign capture   = (state == S_CAP) && out_free;
   assign in_ready  = start;
   assign rnd_ready = start;
   assign busy      = (state != S_IDLE) || out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LB;
         S_LB:    state_nxt = S_LA;
         S_LA:    state_nxt = S_CAP;
         S_CAP:   if (capture) state_nxt = start ? S_LB : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Share buses are gated by state decode so they stay zero outside their slot.
   always_comb begin
      g_ina = '0;
      g_inb = '0;
      g_rnd = '0;
      g_en  = 1'b0;
      case (state)
         S_LB: begin
            g_inb = b_reg;
            g_rnd = r_reg;
            g_en  = 1'b1;
         end
         S_LA: begin
            g_ina = a_reg;
            g_en  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         r_reg     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (start) begin
            a_reg <= in_a;
            b_reg <= in_b;
            r_reg <= rnd_in;
         end else begin
            // Wipe shares and randomness as soon as the gadget has consumed them.
            if (state == S_LB) begin
               b_reg <= '0;
               r_reg <= '0;
            end
            if (state == S_LA) begin
               a_reg <= '0;
            end
         end
         if (capture) begin
            out_data  <= g_out;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_msk_and_pini2_seq.sv
// tb_msk_and_pini2_seq: directed self-checking bench with a behavioural 2-cycle PINI AND gadget.
`default_nettype none

module tb_msk_and_pini2_seq;

   localparam int D  = 2;
   localparam int NR = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [D-1:0]  in_a = '0;
   logic [D-1:0]  in_b = '0;
   logic          rnd_valid = 1'b0;
   logic          rnd_ready;
   logic [NR-1:0] rnd_in = '0;
   logic [D-1:0]  g_ina;
   logic [D-1:0]  g_inb;
   logic [NR-1:0] g_rnd;
   logic          g_en;
   logic [D-1:0]  g_out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [D-1:0]  out_data;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;
   int rnd_cnt = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   msk_and_pini2_seq #(.D(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
      .g_ina(g_ina), .g_inb(g_inb), .g_rnd(g_rnd), .g_en(g_en), .g_out(g_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [D-1:0] gf(input logic [D-1:0] a, input logic [D-1:0] b,
                                       input logic [NR-1:0] r);
      logic [D-1:0] o;
      o[0] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ r[0];
      o[1] = (a[1] & b[0]) ^ (a[1] & b[1]) ^ r[0];
      return o;
   endfunction

   // Gadget model: first enabled cycle latches inb/rnd, second latches ina and computes.
   logic          ph;
   logic [D-1:0]  gb_q;
   logic [NR-1:0] gr_q;
   logic [D-1:0]  gout_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= 1'b0; gb_q <= '0; gr_q <= '0; gout_q <= '0;
      end else if (g_en) begin
         if (!ph) begin
            gb_q <= g_inb; gr_q <= g_rnd; ph <= 1'b1;
         end else begin
            gout_q <= gf(g_ina, gb_q, gr_q); ph <= 1'b0;
         end
      end
   end
   assign g_out = gout_q;

   // Hygiene, handshake pairing and result scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check_val("rdy_pair", {31'd0, rnd_ready}, {31'd0, in_ready});
         if (!(g_en && ph)) check_val("ina_zero", {30'd0, g_ina}, 32'd0);
         if (!(g_en && !ph)) begin
            check_val("inb_zero", {30'd0, g_inb}, 32'd0);
            check_val("rnd_zero", {31'd0, g_rnd}, 32'd0);
         end
         if (g_rnd != '0) rnd_cnt++;
         if (in_valid && in_ready)
            exp_q.push_back({(^in_a) & (^in_b), gf(in_a, in_b, rnd_in)});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_out", 32'd1, 32'd0);
            end else begin
               logic [2:0] e;
               e = exp_q.pop_front();
               check_val("out_xor", {31'd0, ^out_data}, {31'd0, e[2]});
               check_val("out_data", {30'd0, out_data}, {30'd0, e[1:0]});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic set_op(input logic [D-1:0] a, input logic [D-1:0] b, input logic [NR-1:0] r);
      in_a = a; in_b = b; rnd_in = r; in_valid = 1'b1; rnd_valid = 1'b1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; rnd_valid = 1'b0; in_a = '0; in_b = '0; rnd_in = '0;
   endtask

   logic [D-1:0] b2b_a [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
   logic [D-1:0] b2b_b [4] = '{2'b01, 2'b11, 2'b10, 2'b01};

   initial begin
      int acc[$];
      int k;
      int cyc;
      logic [D-1:0] first_data;

      // Reset state
      repeat (2) @(posedge clk);
      samp();
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_g_en", {31'd0, g_en}, 32'd0);
      check_val("rst_out_data", {30'd0, out_data}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      rst_n = 1'b1;

      // Basic op: cycle 0 accept, g_en on cycles 1-2, out_valid at cycle 4
      tick();
      out_ready = 1'b1;
      set_op(2'b01, 2'b10, 1'b1);
      samp();
      check_val("basic_c0_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("basic_c0_g_en", {31'd0, g_en}, 32'd0);
      tick(); idle_inputs();
      samp();
      check_val("basic_c1_g_en", {31'd0, g_en}, 32'd1);
      check_val("basic_c1_g_inb", {30'd0, g_inb}, 32'd2);
      check_val("basic_c1_g_rnd", {31'd0, g_rnd}, 32'd1);
      check_val("basic_c1_in_ready", {31'd0, in_ready}, 32'd0);
      tick(); samp();
      check_val("basic_c2_g_en", {31'd0, g_en}, 32'd1);
      check_val("basic_c2_g_ina", {30'd0, g_ina}, 32'd1);
      tick(); samp();
      check_val("basic_c3_g_en", {31'd0, g_en}, 32'd0);
      check_val("basic_c3_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("basic_c3_busy", {31'd0, busy}, 32'd1);
      tick(); samp();
      check_val("basic_c4_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("basic_c4_xor", {31'd0, ^out_data}, 32'd1);
      tick(); samp();
      check_val("basic_c5_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("basic_c5_busy", {31'd0, busy}, 32'd0);

      // Back-to-back: accepts every 3 cycles, each rnd word used once
      tick();
      rnd_cnt = 0;
      k = 0; cyc = 0;
      set_op(b2b_a[0], b2b_b[0], 1'b1);
      for (int c = 0; c < 20 && k < 4; c++) begin
         samp();
         if (in_ready) begin
            acc.push_back(cyc);
            k++;
         end
         tick();
         cyc++;
         if (k < 4) set_op(b2b_a[k], b2b_b[k], 1'b1);
         else idle_inputs();
      end
      check_val("b2b_accepts", k, 32'd4);
      for (int i = 1; i < acc.size(); i++)
         check_val("b2b_spacing", acc[i] - acc[0], 3 * i);
      repeat (6) tick();
      samp();
      check_val("b2b_rnd_uses", rnd_cnt, 32'd4);
      check_val("b2b_drained", exp_q.size(), 32'd0);

      // Randomness starvation
      tick();
      in_a = 2'b11; in_b = 2'b11; rnd_in = 1'b0; in_valid = 1'b1; rnd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         samp();
         check_val("starve_in_ready", {31'd0, in_ready}, 32'd0);
         check_val("starve_rnd_ready", {31'd0, rnd_ready}, 32'd0);
         check_val("starve_busy", {31'd0, busy}, 32'd0);
         tick();
      end
      rnd_valid = 1'b1;
      samp();
      check_val("starve_accept", {31'd0, in_ready}, 32'd1);
      tick(); idle_inputs();
      repeat (5) tick();
      samp();
      check_val("starve_drained", exp_q.size(), 32'd0);

      // Output backpressure: A accepted at c0, B at c3, B stalls in CAP
      tick();
      set_op(2'b10, 2'b11, 1'b1);
      samp();
      check_val("bp_accept_a", {31'd0, in_ready}, 32'd1);
      tick();
      out_ready = 1'b0;
      set_op(2'b01, 2'b01, 1'b0);
      samp(); check_val("bp_c1_in_ready", {31'd0, in_ready}, 32'd0);
      tick(); samp(); check_val("bp_c2_in_ready", {31'd0, in_ready}, 32'd0);
      tick(); samp(); check_val("bp_accept_b", {31'd0, in_ready}, 32'd1);
      tick(); idle_inputs();
      samp();
      check_val("bp_c4_out_valid", {31'd0, out_valid}, 32'd1);
      first_data = out_data;
      check_val("bp_c4_data_a", {30'd0, out_data}, {30'd0, gf(2'b10, 2'b11, 1'b1)});
      tick(); tick();
      for (int i = 0; i < 2; i++) begin
         samp();
         check_val("bp_stall_g_en", {31'd0, g_en}, 32'd0);
         check_val("bp_stall_valid", {31'd0, out_valid}, 32'd1);
         check_val("bp_stall_data", {30'd0, out_data}, {30'd0, first_data});
         check_val("bp_stall_busy", {31'd0, busy}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      samp();
      check_val("bp_release_data_a", {30'd0, out_data}, {30'd0, first_data});
      tick(); samp();
      check_val("bp_b_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_b_data", {30'd0, out_data}, {30'd0, gf(2'b01, 2'b01, 1'b0)});
      tick(); samp();
      check_val("bp_done_valid", {31'd0, out_valid}, 32'd0);
      check_val("bp_drained", exp_q.size(), 32'd0);

      // Async reset during LA aborts the op
      tick();
      set_op(2'b11, 2'b11, 1'b1);
      samp();
      check_val("ar_accept", {31'd0, in_ready}, 32'd1);
      tick(); idle_inputs();
      tick(); samp();
      check_val("ar_in_la", {30'd0, g_ina}, 32'd3);
      #1 rst_n = 1'b0;
      #1;
      check_val("ar_g_en", {31'd0, g_en}, 32'd0);
      check_val("ar_g_ina", {30'd0, g_ina}, 32'd0);
      check_val("ar_busy", {31'd0, busy}, 32'd0);
      check_val("ar_out_valid", {31'd0, out_valid}, 32'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         samp();
         check_val("ar_no_stale_out", {31'd0, out_valid}, 32'd0);
         tick();
      end
      set_op(2'b10, 2'b01, 1'b1);
      samp();
      check_val("ar_new_accept", {31'd0, in_ready}, 32'd1);
      tick(); idle_inputs();
      tick(); tick(); samp();
      check_val("ar_new_pending", {31'd0, out_valid}, 32'd0);
      tick(); samp();
      check_val("ar_new_valid", {31'd0, out_valid}, 32'd1);
      check_val("ar_new_xor", {31'd0, ^out_data}, 32'd1);
      tick(); samp();
      check_val("ar_final_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
